// File: rtl/inst_fetch_queue_pkg.sv
// Shared widths, instruction encodings and FSM states for the instruction fetch queue.
package inst_fetch_queue_pkg;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned INST_W = 32;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [0:0] {
    IFQ_FETCH   = 1'b0,
    IFQ_DISCARD = 1'b1
  } ifq_state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/inst_fetch_queue_sync_fifo.sv
// Synchronous FIFO with flush; head word is presented directly from storage.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  input  logic                       flush,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    full     = (count == CW'(DEPTH));
    empty    = (count == '0);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    pop_data = mem[rd_ptr];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      mem    <= '{default: '0};
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_next(rd_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: PC generation, memory requests, prefetch queue, redirect flush.
// Define IFQ_PERF_CNT_EN to add saturating perf_fetched/perf_dropped/perf_stall counters.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              mem_req_valid,
  output logic [29:0]       mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_rsp_valid,
  input  logic [INST_W-1:0] mem_rsp_data,
  output logic              out_valid,
  output logic [INST_W-1:0] out_inst,
  output logic [PC_W-1:0]   out_pc,
  input  logic              out_ready
`ifdef IFQ_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_dropped,
  output logic [31:0]       perf_stall
`endif
);

  localparam int unsigned QCW = $clog2(DEPTH + 1);
  localparam int unsigned OCW = $clog2(MAX_OUTSTANDING + 1);

  ifq_state_t               state;
  logic [PC_W-1:0]          fetch_pc;
  logic [OCW-1:0]           drop_cnt;
  logic [OCW-1:0]           drop_new;
  logic [OCW-1:0]           pcf_count;
  logic [QCW-1:0]           q_count;
  logic [PC_W-1:0]          rsp_pc;
  logic [PC_W+INST_W-1:0]   q_head;
  logic                     q_empty, q_full, pcf_full, pcf_empty;
  logic                     req_fire, rsp_push, rsp_drop, q_pop;
  logic                     unused_fifo_flags;

  assign unused_fifo_flags = q_full | pcf_empty;

  always_comb begin
    mem_req_valid = !RST && (state == IFQ_FETCH) && !pcf_full
                    && ((32'(q_count) + 32'(pcf_count)) < DEPTH);
    mem_req_addr  = fetch_pc[31:2];
    req_fire      = mem_req_valid && mem_req_ready;
    // Everything still owed by memory after this edge is stale once a redirect lands.
    drop_new      = pcf_count + OCW'(req_fire) - OCW'(mem_rsp_valid);
    rsp_push      = mem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
    rsp_drop      = mem_rsp_valid && (drop_cnt != '0);
    out_valid     = !q_empty;
    q_pop         = out_valid && out_ready && !redirect_valid;
    out_pc        = q_head[PC_W+INST_W-1:INST_W];
    out_inst      = q_head[INST_W-1:0];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IFQ_FETCH;
      fetch_pc <= RESET_PC;
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & ~32'd3;
      drop_cnt <= drop_new;
      state    <= (drop_new != '0) ? IFQ_DISCARD : IFQ_FETCH;
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + 32'd4;
      if (rsp_drop) begin
        drop_cnt <= drop_cnt - OCW'(1);
        if (drop_cnt == OCW'(1)) state <= IFQ_FETCH;
      end
    end
  end

  sync_fifo #(.WIDTH(PC_W), .DEPTH(MAX_OUTSTANDING)) u_pc_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (mem_rsp_valid),
    .pop_data  (rsp_pc),
    .flush     (1'b0),
    .full      (pcf_full),
    .empty     (pcf_empty),
    .count     (pcf_count)
  );

  sync_fifo #(.WIDTH(PC_W + INST_W), .DEPTH(DEPTH)) u_queue (
    .CLK       (CLK),
    .RST       (RST),
    .push      (rsp_push),
    .push_data ({rsp_pc, mem_rsp_data}),
    .pop       (q_pop),
    .pop_data  (q_head),
    .flush     (redirect_valid),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

`ifdef IFQ_PERF_CNT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
      perf_stall   <= '0;
    end else begin
      if (rsp_push)                   perf_fetched <= sat_inc(perf_fetched);
      if (mem_rsp_valid && !rsp_push) perf_dropped <= sat_inc(perf_dropped);
      if (!out_valid)                 perf_stall   <= sat_inc(perf_stall);
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: queue-based reference model checked every cycle plus directed scenarios.
module tb_inst_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam int          MAXO     = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RST;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req_valid;
  logic [29:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_ready;
`ifdef IFQ_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_dropped, perf_stall;
`endif

  int checks = 0;
  int errors = 0;

  inst_fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .out_valid      (out_valid),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_ready      (out_ready)
`ifdef IFQ_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_dropped   (perf_dropped),
    .perf_stall     (perf_stall)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return 32'hA5C3_0000 ^ {2'b00, a};
  endfunction

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: in-flight requests carry a stale mark instead of a drop counter.
  typedef struct {
    logic [31:0] pc;
    bit          stale;
  } req_t;

  req_t        m_inflight[$];
  logic [63:0] m_q[$];
  logic [31:0] m_pc;
  bit          m_init = 1'b0;

  function automatic bit m_any_stale();
    foreach (m_inflight[i]) if (m_inflight[i].stale) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_req_valid();
    return !RST && !m_any_stale() && (m_inflight.size() < MAXO)
           && ((m_q.size() + m_inflight.size()) < DEPTH);
  endfunction

  function automatic void m_update();
    bit   fire;
    bit   pop;
    req_t r;
    if (RST) begin
      m_inflight.delete();
      m_q.delete();
      m_pc   = RESET_PC;
      m_init = 1'b1;
      return;
    end
    if (!m_init) return;
    fire = m_req_valid() && mem_req_ready;
    pop  = (m_q.size() != 0) && out_ready;
    if (redirect_valid) m_q.delete();
    else if (pop) void'(m_q.pop_front());
    if (mem_rsp_valid) begin
      chk("rsp_has_request", 64'(m_inflight.size() != 0), 64'd1);
      if (m_inflight.size() != 0) begin
        r = m_inflight.pop_front();
        if (!r.stale && !redirect_valid) m_q.push_back({r.pc, mem_word(r.pc[31:2])});
      end
    end
    if (fire) m_inflight.push_back('{pc: m_pc, stale: 1'b0});
    if (redirect_valid) begin
      foreach (m_inflight[i]) m_inflight[i].stale = 1'b1;
      m_pc = redirect_pc & ~32'd3;
    end else if (fire) begin
      m_pc = m_pc + 32'd4;
    end
  endfunction

  // Memory environment state, sampled mid-cycle.
  logic [29:0] mem_q[$];
  bit          rsp_en    = 1'b0;
  bit          env_fire  = 1'b0;
  bit          env_rsp   = 1'b0;
  bit          env_rst   = 1'b0;
  logic [29:0] env_addr  = '0;

  always @(negedge CLK) begin
    env_fire = mem_req_valid && mem_req_ready;
    env_addr = mem_req_addr;
    env_rsp  = mem_rsp_valid;
    env_rst  = RST;
    if (m_init) begin
      chk("cyc_req_valid", 64'(mem_req_valid), 64'(m_req_valid()));
      chk("cyc_req_addr", 64'(mem_req_addr), 64'(m_pc[31:2]));
      chk("cyc_out_valid", 64'(out_valid), 64'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        chk("cyc_out_pc", 64'(out_pc), 64'(m_q[0][63:32]));
        chk("cyc_out_inst", 64'(out_inst), 64'(m_q[0][31:0]));
      end
    end
    m_update();
  end

  task automatic drive_mem();
    mem_rsp_valid = rsp_en && (mem_q.size() != 0);
    mem_rsp_data  = (mem_q.size() != 0) ? mem_word(mem_q[0]) : 32'h0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    if (env_rst) mem_q.delete();
    else begin
      if (env_rsp && mem_q.size() != 0) void'(mem_q.pop_front());
      if (env_fire) mem_q.push_back(env_addr);
    end
    drive_mem();
  endtask

  task automatic wait_out(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 12) begin
      tick();
      n++;
    end
    chk({name, "_arrive"}, 64'(out_valid), 64'd1);
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
    #1;
  endtask

  initial begin
    int n_valid;
    RST = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; out_ready = 1'b0;

    // T1 reset
    tick(); tick();
    chk("t1_rst_req_valid", 64'(mem_req_valid), 64'd0);
    chk("t1_rst_out_valid", 64'(out_valid), 64'd0);
    chk("t1_rst_out_pc", 64'(out_pc), 64'd0);
    chk("t1_rst_out_inst", 64'(out_inst), 64'd0);
    RST = 1'b0; #1;
    chk("t1_req_valid", 64'(mem_req_valid), 64'd1);
    chk("t1_req_addr", 64'(mem_req_addr), 64'd0);

    // T2 streaming
    mem_req_ready = 1'b1; out_ready = 1'b1; rsp_en = 1'b1; drive_mem();
    n_valid = 0;
    for (int c = 0; c < 12; c++) begin
      if (out_valid) begin
        chk($sformatf("t2_pc%0d", n_valid), 64'(out_pc), 64'(n_valid * 4));
        n_valid++;
      end
      tick();
    end
    chk("t2_count", 64'(n_valid), 64'd10);

    // T3 backpressure
    out_ready = 1'b0;
    repeat (6) tick();
    chk("t3_full_valid", 64'(out_valid), 64'd1);
    chk("t3_req_stalled", 64'(mem_req_valid), 64'd0);
    chk("t3_req_addr", 64'(mem_req_addr), 64'h0E);
    chk("t3_head_pc", 64'(out_pc), 64'h28);
    mem_req_ready = 1'b0; out_ready = 1'b1;
    n_valid = 0;
    for (int k = 0; k < 6; k++) begin
      if (out_valid) begin
        chk($sformatf("t3_drain_pc%0d", n_valid), 64'(out_pc), 64'(32'h28 + n_valid * 4));
        n_valid++;
      end
      tick();
    end
    chk("t3_drain_count", 64'(n_valid), 64'd4);

    // T4 redirect with two requests in flight
    mem_req_ready = 1'b1; rsp_en = 1'b0; drive_mem();
    tick(); tick();
    chk("t4_two_outstanding", 64'(mem_req_valid), 64'd0);
    redirect(32'h0000_0100);
    for (int k = 0; k < 2; k++) begin
      chk("t4_discard_idle", 64'(mem_req_valid), 64'd0);
      tick();
    end
    rsp_en = 1'b1; drive_mem();
    for (int k = 0; k < 2; k++) begin
      chk("t4_discard_drop", 64'(mem_req_valid | out_valid), 64'd0);
      tick();
    end
    chk("t4_refetch_valid", 64'(mem_req_valid), 64'd1);
    chk("t4_refetch_addr", 64'(mem_req_addr), 64'h40);
    wait_out("t4");
    chk("t4_out_pc", 64'(out_pc), 64'h100);
    chk("t4_out_inst", 64'(out_inst), 64'hA5C3_0040);

    // T5a unaligned redirect target
    mem_req_ready = 1'b0;
    repeat (4) tick();
    redirect(32'h0000_0103);
    chk("t5a_req_valid", 64'(mem_req_valid), 64'd1);
    chk("t5a_req_addr", 64'(mem_req_addr), 64'h40);
    chk("t5a_flushed", 64'(out_valid), 64'd0);

    // T5b PC wrap
    redirect(32'hFFFF_FFFC);
    chk("t5b_addr_top", 64'(mem_req_addr), 64'h3FFF_FFFF);
    mem_req_ready = 1'b1;
    tick();
    chk("t5b_addr_wrap", 64'(mem_req_addr), 64'h0);
    wait_out("t5b");
    chk("t5b_out_top", 64'(out_pc), 64'hFFFF_FFFC);
    tick();
    chk("t5b_out_wrap", 64'(out_pc), 64'h0);

    // T5c redirect + pop + response in one cycle
    repeat (3) tick();
    chk("t5c_setup", 64'({out_valid, mem_req_valid, mem_rsp_valid}), 64'b111);
    redirect(32'h0000_0200);
    chk("t5c_flushed", 64'(out_valid), 64'd0);
    chk("t5c_discard", 64'(mem_req_valid), 64'd0);
    wait_out("t5c");
    chk("t5c_out_pc", 64'(out_pc), 64'h200);

    // T6 reset with a full queue
    out_ready = 1'b0;
    repeat (8) tick();
    chk("t6_full", 64'({out_valid, mem_req_valid}), 64'b10);
    RST = 1'b1;
    tick();
    chk("t6_rst_out_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_req_valid", 64'(mem_req_valid), 64'd0);
    chk("t6_rst_out_pc", 64'(out_pc), 64'd0);
    chk("t6_rst_out_inst", 64'(out_inst), 64'd0);
    RST = 1'b0; #1;
    chk("t6_req_valid", 64'(mem_req_valid), 64'd1);
    chk("t6_req_addr", 64'(mem_req_addr), 64'(RESET_PC[31:2]));
    out_ready = 1'b1;
    wait_out("t6");
    chk("t6_out_pc", 64'(out_pc), 64'h0);
    chk("t6_out_inst", 64'(out_inst), 64'hA5C3_0000);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required completion before 200000");
    $fatal(1);
  end

endmodule
